imem_fetch_port: RTL and testbench

//  Parametrised, loadable instruction memory for the RISC-V core: word storage, a sequential loader

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_fetch_port_if.sv | 46 ++++
 rtl/imem_array.sv | 24 ++
 rtl/imem_fetch_port.sv | 143 ++++++++++++++
 tb/tb_imem_fetch_port.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Build with IMEM_PARITY_EN defined to store and check a parity bit per word.
package imem_pkg;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_RANGE    = 2'b10,
      ERR_PARITY   = 2'b11
   } rsp_err_t;

   localparam int PAR_MAX_W = 64;

   // Bit that makes the total number of ones (word + bit) even.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Loader, reload control and fetch request/response signals of the instruction memory.
// IMEM_PARITY_EN adds the ld_par_flip fault-injection input.
interface imem_fetch_port_if
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Every channel is valid/ready: a beat transfers on a rising edge where both are high; the
   // source holds its payload stable while valid is high and ready is low.
   logic                  ld_valid;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  ld_last;
   logic                  ld_ready;
`ifdef IMEM_PARITY_EN
   logic                  ld_par_flip;
`endif
   logic                  reload;
   logic                  loaded;
   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;
   rsp_err_t              rsp_err;
   logic                  rsp_ready;

   modport slave (
      input  ld_valid, ld_data, ld_last,
`ifdef IMEM_PARITY_EN
      input  ld_par_flip,
`endif
      input  reload, req_valid, req_addr, rsp_ready,
      output ld_ready, loaded, req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output ld_valid, ld_data, ld_last,
`ifdef IMEM_PARITY_EN
      output ld_par_flip,
`endif
      output reload, req_valid, req_addr, rsp_ready,
      input  ld_ready, loaded, req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/imem_array.sv
// DEPTH x WIDTH word storage: synchronous write, synchronous read with read enable.
// The read register holds its value while re is low; contents are never reset.
module imem_array #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [IDX_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_fetch_port.sv
// Loadable instruction memory: sequential loader, LOAD/RUN FSM and a 1-cycle valid/ready fetch port.
// IMEM_PARITY_EN enables per-word parity storage and checking.
module imem_fetch_port
   import imem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   imem_fetch_port_if.slave   bus,
   output state_t             dbg_state
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
`else
   localparam int MEM_W = DATA_WIDTH;
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] wp_q, wp_d;
   logic             reload_pend_q, reload_pend_d;
   logic             rsp_valid_q, rsp_valid_d;
   rsp_err_t         addr_err_q, addr_err_d;
   logic             data_ok_q, data_ok_d;

   logic                  rsp_free, ld_fire, req_fire, rsp_fire, re;
   logic [ADDR_WIDTH-1:0] req_idx;
   rsp_err_t              req_err;
   logic [MEM_W-1:0]      wdata, rdata;

   assign rsp_free      = !rsp_valid_q || bus.rsp_ready;
   assign bus.ld_ready  = (state_q == S_LOAD);
   assign bus.loaded    = (state_q == S_RUN);
   // No new fetch is taken once a reload has been requested.
   assign bus.req_ready = (state_q == S_RUN) && rsp_free && !bus.reload && !reload_pend_q;
   assign ld_fire       = bus.ld_valid && bus.ld_ready && !bus.reload;
   assign req_fire      = bus.req_valid && bus.req_ready;
   assign rsp_fire      = rsp_valid_q && bus.rsp_ready;
   assign req_idx       = bus.req_addr >> 2;
   assign dbg_state     = state_q;

   always_comb begin
      req_err = ERR_OK;
      if (bus.req_addr[1:0] != 2'b00)            req_err = ERR_MISALIGN;
      else if (req_idx >= ADDR_WIDTH'(DEPTH))    req_err = ERR_RANGE;
   end

   always_comb begin
      state_d       = state_q;
      wp_d          = wp_q;
      reload_pend_d = reload_pend_q;
      case (state_q)
         S_LOAD: begin
            if (bus.reload) begin
               wp_d = '0;
            end else if (ld_fire) begin
               wp_d = wp_q + 1'b1;
               if (bus.ld_last || wp_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if ((bus.reload || reload_pend_q) && rsp_free) begin
               state_d       = S_LOAD;
               wp_d          = '0;
               reload_pend_d = 1'b0;
            end else if (bus.reload) begin
               reload_pend_d = 1'b1;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      addr_err_d  = addr_err_q;
      data_ok_d   = data_ok_q;
      if (req_fire) begin
         rsp_valid_d = 1'b1;
         addr_err_d  = req_err;
         data_ok_d   = (req_err == ERR_OK);
      end else if (rsp_fire) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_LOAD;
         wp_q          <= '0;
         reload_pend_q <= 1'b0;
         rsp_valid_q   <= 1'b0;
         addr_err_q    <= ERR_OK;
         data_ok_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wp_q          <= wp_d;
         reload_pend_q <= reload_pend_d;
         rsp_valid_q   <= rsp_valid_d;
         addr_err_q    <= addr_err_d;
         data_ok_q     <= data_ok_d;
      end
   end

   // The array is read only for in-range aligned requests, so a stalled response stays put.
   assign re = req_fire && (req_err == ERR_OK);

`ifdef IMEM_PARITY_EN
   assign wdata = {even_parity(PAR_MAX_W'(bus.ld_data)) ^ bus.ld_par_flip, bus.ld_data};
`else
   assign wdata = bus.ld_data;
`endif

   imem_array #(
      .DEPTH (DEPTH),
      .WIDTH (MEM_W),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (ld_fire),
      .waddr (wp_q),
      .wdata (wdata),
      .re    (re),
      .raddr (bus.req_addr[IDX_W+1:2]),
      .rdata (rdata)
   );

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = data_ok_q ? rdata[DATA_WIDTH-1:0] : '0;

   always_comb begin
      bus.rsp_err = addr_err_q;
`ifdef IMEM_PARITY_EN
      if (data_ok_q && (even_parity(PAR_MAX_W'(rdata[DATA_WIDTH-1:0])) != rdata[DATA_WIDTH]))
         bus.rsp_err = ERR_PARITY;
`endif
   end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised scoreboard bench for imem_fetch_port with an array-based reference memory.
// Parity scenarios run only when IMEM_PARITY_EN is defined.
module tb_imem_fetch_port;
   import imem_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;

   imem_fetch_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   imem_fetch_port #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] ref_mem  [DEPTH];
   bit            ref_flip [DEPTH];
   logic [DW+1:0] exp_q[$];   // {err, data}
   int            n_checks = 0;
   int            n_errors = 0;
   int            rsp_mode = 0; // 0 always ready, 1 random, 2 held low
   logic [DW-1:0] prog5 [5] = '{32'h0000_0013, 32'h00A0_0093, 32'h0010_0113,
                                32'h0020_81B3, 32'h0000_006F};

   function automatic logic [DW+1:0] ref_fetch(input logic [AW-1:0] a);
      if (a % 4 != 0)            return {2'b01, {DW{1'b0}}};
      if (a / 4 >= 32'(DEPTH))   return {2'b10, {DW{1'b0}}};
      return {(ref_flip[a / 4] ? 2'b11 : 2'b00), ref_mem[a / 4]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- response stall control ----------------
   always @(negedge clk) begin
      case (rsp_mode)
         0:       bus.rsp_ready = 1'b1;
         1:       bus.rsp_ready = 1'($urandom_range(0, 1));
         default: bus.rsp_ready = 1'b0;
      endcase
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      #1;
      if (rst_n && bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got response %h/%0d, expected no response", bus.rsp_data, bus.rsp_err);
         end else begin
            chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0][DW-1:0]));
            chk("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0][DW+1:DW]));
            if (bus.rsp_ready) void'(exp_q.pop_front());
         end
         if (!bus.rsp_ready) chk("req_ready_during_stall", 64'(bus.req_ready), 64'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_prog(input int n, input bit use_last, input bit use_prog5, input int flip_idx);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         w = use_prog5 ? prog5[i] : $urandom;
         bus.ld_valid = 1'b1;
         bus.ld_data  = w;
         bus.ld_last  = use_last && (i == n - 1);
`ifdef IMEM_PARITY_EN
         bus.ld_par_flip = (i == flip_idx);
`endif
         #1;
         chk("ld_ready_beat", 64'(bus.ld_ready), 64'd1);
         chk("loaded_during_load", 64'(bus.loaded), 64'd0);
         ref_mem[i]  = w;
         ref_flip[i] = (i == flip_idx);
      end
      // One extra beat offered after the final one must be refused.
      @(negedge clk);
      bus.ld_data = $urandom;
      bus.ld_last = 1'b0;
`ifdef IMEM_PARITY_EN
      bus.ld_par_flip = 1'b0;
`endif
      #1;
      chk("loaded_after_last", 64'(bus.loaded), 64'd1);
      chk("ld_ready_after_last", 64'(bus.ld_ready), 64'd0);
      @(negedge clk);
      bus.ld_valid = 1'b0;
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      int k;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      k = 0;
      #1;
      while (!bus.req_ready && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (bus.req_ready) exp_q.push_back(ref_fetch(a));
      else chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
   endtask

   task automatic fetch_end();
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reload();
      @(negedge clk);
      bus.reload = 1'b1;
      @(negedge clk);
      bus.reload = 1'b0;
      #1;
      chk("loaded_after_reload", 64'(bus.loaded), 64'd0);
      chk("ld_ready_after_reload", 64'(bus.ld_ready), 64'd1);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7)       return AW'($urandom_range(0, DEPTH - 1)) << 2;
      else if (kind == 7) return (AW'($urandom_range(0, DEPTH - 1)) << 2) | AW'($urandom_range(1, 3));
      else if (kind == 8) return AW'($urandom_range(DEPTH, 4096)) << 2;
      else                return {$urandom} & 32'hFFFF_FFFC | 32'h8000_0000;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      rst_n         = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.ld_data   = '0;
      bus.ld_last   = 1'b0;
`ifdef IMEM_PARITY_EN
      bus.ld_par_flip = 1'b0;
`endif
      bus.reload    = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_flip[i] = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("reset_ld_ready", 64'(bus.ld_ready), 64'd1);
      chk("reset_loaded", 64'(bus.loaded), 64'd0);
      chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
      rst_n = 1'b1;

      // Five-word program terminated by ld_last, then fetch each word.
      load_prog(5, 1'b1, 1'b1, -1);
      for (int i = 0; i < 5; i++) fetch(AW'(i * 4));
      fetch_end();
      wait_drain();

      // Address errors, including full-width range checks with no aliasing.
      fetch(32'h0000_0006);
      fetch(AW'(DEPTH * 4));
      fetch(32'hFFFF_FFFC);
      fetch(32'h4000_0000);
      fetch(32'h0000_0003);
      fetch_end();
      wait_drain();

      // Fill the whole array without ld_last.
      do_reload();
      load_prog(DEPTH, 1'b0, 1'b0, -1);

      // Random fetches under random back-pressure.
      rsp_mode = 1;
      for (int i = 0; i < 80; i++) fetch(rand_addr());
      fetch_end();
      wait_drain();
      rsp_mode = 0;

      // Back-to-back stream with rsp_ready low for three cycles mid-stream.
      fork
         begin
            for (int i = 0; i < 20; i++) fetch(AW'($urandom_range(0, DEPTH - 1)) << 2);
            fetch_end();
         end
         begin
            repeat (6) @(negedge clk);
            #1 rsp_mode = 2;
            repeat (3) @(negedge clk);
            #1 rsp_mode = 0;
         end
      join
      wait_drain();

      // Reload requested while a response is stalled: LOAD only after the handshake.
      @(negedge clk);
      #1 rsp_mode = 2;
      fetch(32'h0000_0004);
      fetch_end();
      @(negedge clk);
      bus.reload = 1'b1;
      #1;
      chk("req_ready_on_reload", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      bus.reload = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("loaded_while_stalled", 64'(bus.loaded), 64'd1);
         chk("req_ready_reload_pending", 64'(bus.req_ready), 64'd0);
      end
      rsp_mode = 0;
      @(negedge clk);
      #1;
      chk("loaded_until_handshake", 64'(bus.loaded), 64'd1);
      @(negedge clk);
      #1;
      chk("loaded_after_handshake", 64'(bus.loaded), 64'd0);
      chk("ld_ready_after_handshake", 64'(bus.ld_ready), 64'd1);
      wait_drain();

      // New program; words beyond it keep their earlier contents.
      load_prog(5, 1'b1, 1'b0, -1);
      for (int i = 0; i < 5; i++) fetch(AW'(i * 4));
      fetch(AW'((DEPTH - 1) * 4));
      fetch(32'h0000_001C);
      fetch_end();
      wait_drain();

`ifdef IMEM_PARITY_EN
      do_reload();
      load_prog(5, 1'b1, 1'b1, 2);
      for (int i = 0; i < 5; i++) fetch(AW'(i * 4));
      fetch(32'h0000_000A);
      fetch_end();
      wait_drain();
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
